// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream style routing blocks: destination index,
// packet-routing FSM states and the lane count.
package axis_pkg;

  localparam int N_PORTS = 4;

  typedef logic [1:0] axis_dest_t;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } axis_route_state_t;

  // One-hot lane mask for a destination index.
  function automatic logic [N_PORTS-1:0] dest_onehot(input axis_dest_t dest);
    logic [N_PORTS-1:0] mask;
    mask       = '0;
    mask[dest] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry register slice: an output register plus one skid register,
// giving full throughput with a registered upstream ready.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);

  logic [W-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q;

  logic up_fire;
  logic dn_pop;

  assign up_fire = up_valid & ready_q;
  assign dn_pop  = out_valid_q & dn_ready;

  // NOTE: every signal written here gets its hold value first, so no path
  // through the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (skid_valid_q) begin
      // Upstream is stalled while the skid is full; drain it on the next pop.
      if (dn_pop) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (up_fire) begin
      if (!out_valid_q || dn_pop) begin
        out_d       = up_data;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = up_data;
        skid_valid_d = 1'b1;
      end
    end else if (dn_pop) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the payload registers are reset too, so the idle outputs are a
  // defined zero rather than X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign up_ready = ready_q;
  assign dn_data  = out_q;
  assign dn_valid = out_valid_q;

endmodule

// File: rtl/axis_demux_1to4.sv
// 1-to-4 packet demultiplexer: the destination is latched on the first beat of a
// packet and held until the last beat is accepted, so packets are never split.
module axis_demux_1to4
  import axis_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] data,
  input  logic             last,
  input  logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] data_0,
  output logic             last_0,
  output logic             valid_0,
  input  logic             ready_0,
  output logic [WIDTH-1:0] data_1,
  output logic             last_1,
  output logic             valid_1,
  input  logic             ready_1,
  output logic [WIDTH-1:0] data_2,
  output logic             last_2,
  output logic             valid_2,
  input  logic             ready_2,
  output logic [WIDTH-1:0] data_3,
  output logic             last_3,
  output logic             valid_3,
  input  logic             ready_3,
  output logic             busy
);

  localparam int SW = WIDTH + 1 + $bits(axis_dest_t);

  axis_route_state_t state_q, state_d;
  axis_dest_t        route_q, route_d;
  axis_dest_t        dest;
  logic              accept;

  logic [SW-1:0]     up_bus;
  logic [SW-1:0]     dn_bus;
  logic              dn_valid;
  logic              dn_ready;

  axis_dest_t        out_dest;
  logic              out_last;
  logic [WIDTH-1:0]  out_data;
  logic [N_PORTS-1:0] ready_v;
  logic [N_PORTS-1:0] valid_v;

  assign accept = valid & ready;

  // ---------------------------------------------------------------------------
  // Packet routing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          route_d = sel;
          if (!last) state_d = PKT;
        end
      end
      PKT: begin
        if (accept && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  assign busy = (state_q == PKT);

  // The first beat routes on the live sel; later beats reuse the latched route.
  assign dest   = (state_q == IDLE) ? sel : route_q;
  assign up_bus = {dest, last, data};

  // ---------------------------------------------------------------------------
  // Datapath register slice carrying {dest, last, data}
  // ---------------------------------------------------------------------------
  axis_skid_buffer #(
    .W (SW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_data  (up_bus),
    .up_valid (valid),
    .up_ready (ready),
    .dn_data  (dn_bus),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready)
  );

  assign {out_dest, out_last, out_data} = dn_bus;

  // ---------------------------------------------------------------------------
  // One-hot steering: only the addressed lane's ready can pop the beat
  // ---------------------------------------------------------------------------
  assign ready_v  = {ready_3, ready_2, ready_1, ready_0};
  assign dn_ready = ready_v[out_dest];
  assign valid_v  = dn_valid ? dest_onehot(out_dest) : '0;

  assign valid_0 = valid_v[0];
  assign valid_1 = valid_v[1];
  assign valid_2 = valid_v[2];
  assign valid_3 = valid_v[3];

  assign data_0 = out_data;
  assign data_1 = out_data;
  assign data_2 = out_data;
  assign data_3 = out_data;

  assign last_0 = out_last;
  assign last_1 = out_last;
  assign last_2 = out_last;
  assign last_3 = out_last;

endmodule
